// File: rtl/neuron_layer_core.sv
// neuron_layer_core: fully-connected layer of N_OUT neurons over N_IN inputs with
// on-chip weight storage. The forward pass walks one input index per cycle with all
// neurons in parallel. The update mode applies a saturating SGD step from per-neuron
// error terms.
// Optional feature macro NEURON_LAYER_RELU_EN: when defined, y_o is ReLU(acc).
// When undefined, y_o is the raw signed accumulator (linear/output layer).
module neuron_layer_core #(
   parameter int N_IN     = 4,
   parameter int N_OUT    = 8,
   parameter int X_W      = 4,
   parameter int W_W      = 8,
   parameter int ERR_W    = 8,
   parameter int ACC_W    = 16,
   parameter int LR_SHIFT = 3
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              start_i,
   input  logic                              mode_i,
   input  logic [N_IN*X_W-1:0]               x_i,
   input  logic [N_OUT*ERR_W-1:0]            err_i,
   input  logic                              wload_i,
   input  logic [$clog2(N_OUT*N_IN)-1:0]     waddr_i,
   input  logic [W_W-1:0]                    wdata_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic [N_OUT*ACC_W-1:0]            y_o,
   output logic [N_OUT*N_IN*W_W-1:0]         weights_o
);

   localparam int N_W  = N_OUT * N_IN;
   localparam int A_W  = $clog2(N_W);
   localparam int K_W  = $clog2(N_IN);
   localparam int PF_W = X_W + W_W + 1;
   localparam int PU_W = ERR_W + X_W + 1;
   localparam int D_W  = ((PU_W > W_W) ? PU_W : W_W) + 1;

   localparam logic [A_W:0]            N_W_L = (A_W + 1)'(N_W);
   localparam logic signed [D_W-1:0]   W_MAX = D_W'((1 << (W_W - 1)) - 1);
   localparam logic signed [D_W-1:0]   W_MIN = ~W_MAX;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FWD,
      S_UPD,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [K_W-1:0]            k_q, k_d;
   logic                      mode_q, mode_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [X_W-1:0]            x_q   [N_IN];
   logic [X_W-1:0]            x_d   [N_IN];
   logic signed [ERR_W-1:0]   err_q [N_OUT];
   logic signed [ERR_W-1:0]   err_d [N_OUT];
   logic signed [ACC_W-1:0]   acc_q [N_OUT];
   logic signed [ACC_W-1:0]   acc_d [N_OUT];
   logic signed [ACC_W-1:0]   y_q   [N_OUT];
   logic signed [ACC_W-1:0]   y_d   [N_OUT];
   logic signed [W_W-1:0]     w_q   [N_W];
   logic signed [W_W-1:0]     w_d   [N_W];

   logic [X_W-1:0]            x_sel;
   logic signed [PF_W-1:0]    x_ext_f;
   logic signed [D_W-1:0]     x_ext_u;
   logic signed [W_W-1:0]     w_sel    [N_OUT];
   logic signed [PF_W-1:0]    prod_f   [N_OUT];
   logic signed [ACC_W-1:0]   acc_next [N_OUT];
   logic signed [D_W-1:0]     prod_u   [N_OUT];
   logic signed [D_W-1:0]     delta    [N_OUT];
   logic signed [D_W-1:0]     diff     [N_OUT];
   logic signed [W_W-1:0]     w_new    [N_OUT];

   // Per-cycle datapath: pick input k and each neuron's weight k, then form the
   // next accumulator value and the saturated updated weight at full width.
   always_comb begin
      x_sel = x_q[0];
      for (int k = 0; k < N_IN; k++) begin
         if (k_q == K_W'(k)) begin
            x_sel = x_q[k];
         end
      end
      x_ext_f = PF_W'($signed({1'b0, x_sel}));
      x_ext_u = D_W'($signed({1'b0, x_sel}));
      for (int n = 0; n < N_OUT; n++) begin
         w_sel[n] = w_q[n*N_IN];
         for (int k = 0; k < N_IN; k++) begin
            if (k_q == K_W'(k)) begin
               w_sel[n] = w_q[n*N_IN + k];
            end
         end
         prod_f[n]   = x_ext_f * PF_W'(w_sel[n]);
         acc_next[n] = acc_q[n] + ACC_W'(prod_f[n]);
         prod_u[n]   = D_W'(err_q[n]) * x_ext_u;
         delta[n]    = prod_u[n] >>> LR_SHIFT;
         diff[n]     = D_W'(w_sel[n]) - delta[n];
         if (diff[n] > W_MAX) begin
            w_new[n] = W_W'(W_MAX);
         end else if (diff[n] < W_MIN) begin
            w_new[n] = W_W'(W_MIN);
         end else begin
            w_new[n] = W_W'(diff[n]);
         end
      end
   end

   // Next-state logic: FSM sequencing, input capture, weight loads and updates,
   // accumulation and the output register update on completion.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      x_d     = x_q;
      err_d   = err_q;
      acc_d   = acc_q;
      y_d     = y_q;
      w_d     = w_q;
      case (state_q)
         S_IDLE: begin
            if (wload_i && ({1'b0, waddr_i} < N_W_L)) begin
               w_d[waddr_i] = $signed(wdata_i);
            end
            if (start_i) begin
               mode_d = mode_i;
               k_d    = '0;
               for (int k = 0; k < N_IN; k++) begin
                  x_d[k] = x_i[k*X_W +: X_W];
               end
               for (int n = 0; n < N_OUT; n++) begin
                  err_d[n] = $signed(err_i[n*ERR_W +: ERR_W]);
               end
               if (mode_i) begin
                  state_d = S_UPD;
               end else begin
                  state_d = S_FWD;
                  for (int n = 0; n < N_OUT; n++) begin
                     acc_d[n] = '0;
                  end
               end
            end
         end
         S_FWD: begin
            acc_d = acc_next;
            k_d   = k_q + K_W'(1);
            if (k_q == K_W'(N_IN - 1)) begin
               k_d     = '0;
               state_d = S_DONE;
            end
         end
         S_UPD: begin
            for (int n = 0; n < N_OUT; n++) begin
               for (int k = 0; k < N_IN; k++) begin
                  if (k_q == K_W'(k)) begin
                     w_d[n*N_IN + k] = w_new[n];
                  end
               end
            end
            k_d = k_q + K_W'(1);
            if (k_q == K_W'(N_IN - 1)) begin
               k_d     = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!mode_q) begin
               for (int n = 0; n < N_OUT; n++) begin
`ifdef NEURON_LAYER_RELU_EN
                  y_d[n] = acc_q[n][ACC_W-1] ? '0 : acc_q[n];
`else
                  y_d[n] = acc_q[n];
`endif
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any operation and clears all storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '{default: '0};
         err_q   <= '{default: '0};
         acc_q   <= '{default: '0};
         y_q     <= '{default: '0};
         w_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         x_q     <= x_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         w_q     <= w_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;

   for (genvar g = 0; g < N_OUT; g++) begin : g_y
      assign y_o[g*ACC_W +: ACC_W] = y_q[g];
   end

   for (genvar g = 0; g < N_W; g++) begin : g_w
      assign weights_o[g*W_W +: W_W] = w_q[g];
   end

endmodule
